// File: rtl/round_sequencer.sv
// Pong rally controller: serve/play/point/game-over sequencing, goal detection, score keeping.
// Every output is registered (one-cycle latency from inputs); there is no backpressure, and frame_tick paces SERVE and POINT.
module round_sequencer #(
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int WIN_SCORE    = 9,
  parameter int LEFT_GOAL    = 10,
  parameter int RIGHT_GOAL   = 630
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start_button,
  input  logic       clear_scores,
  input  logic [9:0] ball_x_pos,
  output logic       round_reset,
  output logic       play_enable,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic       point_pulse,
  output logic       left_wins,
  output logic       right_wins,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    POINT     = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [9:0] LEFT_X     = 10'(LEFT_GOAL);
  localparam logic [9:0] RIGHT_X    = 10'(RIGHT_GOAL);

  state_t     state, state_nxt;
  logic [7:0] frame_cnt, frame_cnt_nxt;
  logic [3:0] left_score_nxt, right_score_nxt;
  logic       left_wins_nxt, right_wins_nxt;
  logic       point_pulse_nxt;
  logic       round_reset_nxt, play_enable_nxt;

  logic       ball_in_left_goal, ball_in_right_goal;
  logic [3:0] left_inc, right_inc;

  assign ball_in_left_goal  = (ball_x_pos <= LEFT_X);
  assign ball_in_right_goal = (ball_x_pos >= RIGHT_X);
  assign left_inc           = left_score + 4'd1;
  assign right_inc          = right_score + 4'd1;
  assign state_out          = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      frame_cnt   <= 8'd0;
      left_score  <= 4'd0;
      right_score <= 4'd0;
      left_wins   <= 1'b0;
      right_wins  <= 1'b0;
      point_pulse <= 1'b0;
      round_reset <= 1'b1;
      play_enable <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_cnt   <= frame_cnt_nxt;
      left_score  <= left_score_nxt;
      right_score <= right_score_nxt;
      left_wins   <= left_wins_nxt;
      right_wins  <= right_wins_nxt;
      point_pulse <= point_pulse_nxt;
      round_reset <= round_reset_nxt;
      play_enable <= play_enable_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    frame_cnt_nxt   = frame_cnt;
    left_score_nxt  = left_score;
    right_score_nxt = right_score;
    left_wins_nxt   = left_wins;
    right_wins_nxt  = right_wins;
    point_pulse_nxt = 1'b0;

    if (clear_scores) begin
      state_nxt       = IDLE;
      frame_cnt_nxt   = 8'd0;
      left_score_nxt  = 4'd0;
      right_score_nxt = 4'd0;
      left_wins_nxt   = 1'b0;
      right_wins_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_button) begin
            state_nxt     = SERVE;
            frame_cnt_nxt = 8'd0;
          end
        end
        SERVE: begin
          if (frame_tick) begin
            if (frame_cnt == SERVE_LAST) begin
              state_nxt     = PLAY;
              frame_cnt_nxt = 8'd0;
            end else begin
              frame_cnt_nxt = frame_cnt + 8'd1;
            end
          end
        end
        PLAY: begin
          // A ball past the left edge is a point for the right player, and vice versa.
          if (ball_in_left_goal) begin
            right_score_nxt = right_inc;
            point_pulse_nxt = 1'b1;
            frame_cnt_nxt   = 8'd0;
            if (right_inc == WIN) begin
              state_nxt      = GAME_OVER;
              right_wins_nxt = 1'b1;
            end else begin
              state_nxt = POINT;
            end
          end else if (ball_in_right_goal) begin
            left_score_nxt  = left_inc;
            point_pulse_nxt = 1'b1;
            frame_cnt_nxt   = 8'd0;
            if (left_inc == WIN) begin
              state_nxt     = GAME_OVER;
              left_wins_nxt = 1'b1;
            end else begin
              state_nxt = POINT;
            end
          end
        end
        POINT: begin
          if (frame_tick) begin
            if (frame_cnt == POINT_LAST) begin
              state_nxt     = SERVE;
              frame_cnt_nxt = 8'd0;
            end else begin
              frame_cnt_nxt = frame_cnt + 8'd1;
            end
          end
        end
        GAME_OVER: begin
          if (start_button) begin
            state_nxt       = SERVE;
            frame_cnt_nxt   = 8'd0;
            left_score_nxt  = 4'd0;
            right_score_nxt = 4'd0;
            left_wins_nxt   = 1'b0;
            right_wins_nxt  = 1'b0;
          end
        end
        default: begin
          state_nxt     = IDLE;
          frame_cnt_nxt = 8'd0;
        end
      endcase
    end
  end

  // Derived from the next state so the registered outputs line up with state_out.
  always_comb begin
    round_reset_nxt = 1'b1;
    play_enable_nxt = 1'b0;
    case (state_nxt)
      PLAY: begin
        round_reset_nxt = 1'b0;
        play_enable_nxt = 1'b1;
      end
      POINT:   round_reset_nxt = 1'b0;
      default: round_reset_nxt = 1'b1;
    endcase
  end

endmodule
